// File: rtl/reg_sequencer.sv
// Multi-cycle sequencer feeding a single-port register file; splits each instruction into read/write cycles.
// Optional SEQ_ILLEGAL_HALT_EN: an undefined opcode halts the sequencer instead of being skipped.
module reg_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid,
  input  logic [DATA_WIDTH+7:0]   instr,
  output logic                    instr_ready,
  output logic                    reg_we,
  output logic [ADDR_WIDTH-1:0]   reg_addr,
  output logic [DATA_WIDTH-1:0]   reg_wdata,
  input  logic [DATA_WIDTH-1:0]   reg_rdata,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  input  logic                    out_ready,
  output logic                    flag_z,
  output logic                    flag_c,
  output logic                    illegal,
  output logic                    halted
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_OUT  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_RD_S,
    S_RD_D,
    S_WB,
    S_OUT,
    S_HALT
  } state_t;

  state_t state, state_next;

  logic [3:0]            ir_op;
  logic [ADDR_WIDTH-1:0] ir_rd;
  logic [DATA_WIDTH-1:0] ir_imm;
  logic [ADDR_WIDTH-1:0] ir_rs;
  logic [DATA_WIDTH-1:0] op_a, op_b;

  logic [3:0]            in_op;
  logic                  in_illegal;
  logic                  accept;

  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH:0]   alu_wide;
  logic                  alu_c;
  logic                  alu_flags;

  // Bits between the rd field and the opcode carry no meaning.
  logic unused_bits;
  assign unused_bits = ^instr[DATA_WIDTH+3:DATA_WIDTH+ADDR_WIDTH];

  assign in_op      = instr[DATA_WIDTH+7:DATA_WIDTH+4];
  assign in_illegal = (in_op >= 4'h9) && (in_op <= 4'hE);
  assign accept     = instr_valid && instr_ready;
  assign ir_rs      = ir_imm[ADDR_WIDTH-1:0];

  always_comb begin
    alu_res   = '0;
    alu_wide  = '0;
    alu_c     = 1'b0;
    alu_flags = 1'b0;
    case (ir_op)
      OP_LDI: alu_res = ir_imm;
      OP_MOV: alu_res = op_a;
      OP_ADD: begin
        alu_wide  = {1'b0, op_b} + {1'b0, op_a};
        alu_res   = alu_wide[DATA_WIDTH-1:0];
        alu_c     = alu_wide[DATA_WIDTH];
        alu_flags = 1'b1;
      end
      OP_SUB: begin
        // Top bit of the widened difference is the borrow (opA > opB).
        alu_wide  = {1'b0, op_b} - {1'b0, op_a};
        alu_res   = alu_wide[DATA_WIDTH-1:0];
        alu_c     = alu_wide[DATA_WIDTH];
        alu_flags = 1'b1;
      end
      OP_AND: begin
        alu_res   = op_b & op_a;
        alu_flags = 1'b1;
      end
      OP_OR: begin
        alu_res   = op_b | op_a;
        alu_flags = 1'b1;
      end
      OP_XOR: begin
        alu_res   = op_b ^ op_a;
        alu_flags = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    reg_we      = 1'b0;
    reg_addr    = '0;
    reg_wdata   = '0;
    out_valid   = 1'b0;
    out_data    = '0;
    halted      = 1'b0;
    case (state)
      S_FETCH: begin
        // Held low while reset is asserted so nothing is accepted mid-reset.
        instr_ready = ~rst;
        if (accept) begin
          case (in_op)
            OP_NOP:  state_next = S_FETCH;
            OP_LDI:  state_next = S_WB;
            OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                     state_next = S_RD_S;
            OP_OUT:  state_next = S_RD_D;
            OP_HALT: state_next = S_HALT;
            default: begin
`ifdef SEQ_ILLEGAL_HALT_EN
              state_next = S_HALT;
`else
              state_next = S_FETCH;
`endif
            end
          endcase
        end
      end
      S_RD_S: begin
        reg_addr   = ir_rs;
        state_next = (ir_op == OP_MOV) ? S_WB : S_RD_D;
      end
      S_RD_D: begin
        reg_addr   = ir_rd;
        state_next = (ir_op == OP_OUT) ? S_OUT : S_WB;
      end
      S_WB: begin
        reg_addr   = ir_rd;
        reg_we     = 1'b1;
        reg_wdata  = alu_res;
        state_next = S_FETCH;
      end
      S_OUT: begin
        out_valid = 1'b1;
        out_data  = op_b;
        if (out_ready) state_next = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      ir_op   <= '0;
      ir_rd   <= '0;
      ir_imm  <= '0;
      op_a    <= '0;
      op_b    <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state   <= state_next;
      illegal <= accept && in_illegal;
      if (accept) begin
        ir_op  <= in_op;
        ir_rd  <= instr[DATA_WIDTH+ADDR_WIDTH-1:DATA_WIDTH];
        ir_imm <= instr[DATA_WIDTH-1:0];
      end
      if (state == S_RD_S) op_a <= reg_rdata;
      if (state == S_RD_D) op_b <= reg_rdata;
      // LDI and MOV write back without disturbing the flags.
      if (state == S_WB && alu_flags) begin
        flag_z <= (alu_res == '0);
        flag_c <= alu_c;
      end
    end
  end

endmodule

// File: tb/tb_reg_sequencer.sv
// Self-checking bench for reg_sequencer: directed scenarios plus randomized programs against a behavioural model.
module tb_reg_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        reg_we;
  logic [2:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        flag_z;
  logic        flag_c;
  logic        illegal;
  logic        halted;

  int checks = 0;
  int failures = 0;

  logic [7:0] rf [8];
  logic [7:0] mregs [8];
  logic       mz = 1'b0;
  logic       mc = 1'b0;

  typedef struct {
    int         lat;
    int         nwe;
    logic [2:0] waddr;
    logic [7:0] wdata;
    int         nout;
    logic [7:0] odata;
    int         ill;
    bit         halt;
    logic       z;
    logic       c;
  } exp_t;

  typedef struct {
    int         lat;
    int         nwe;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [2:0] addr1;
    int         nout;
    logic [7:0] odata;
    bit         unstable;
    bit         leak;
    int         ill;
    bit         halt;
  } obs_t;

  reg_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .flag_z(flag_z),
    .flag_c(flag_c), .illegal(illegal), .halted(halted)
  );

  always #5 clk = ~clk;

  // Register file environment: combinational read, write on the clock edge.
  assign reg_rdata = rf[reg_addr];
  always @(posedge clk) if (reg_we) rf[reg_addr] <= reg_wdata;

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd, input logic [7:0] lo);
    return {op, 1'b0, rd, lo};
  endfunction

  // Reference model: instruction semantics with plain integer arithmetic.
  task automatic model_step(input logic [15:0] w, input int stall, output exp_t e);
    logic [3:0] op;
    logic [2:0] rd, rs;
    int a, b, r;
    op = w[15:12]; rd = w[10:8]; rs = w[2:0];
    a = int'(mregs[rs]); b = int'(mregs[rd]); r = 0;
    e = '{default: 0};
    e.z = mz; e.c = mc; e.waddr = rd;
    case (op)
      4'h0: e.lat = 1;
      4'h1: begin e.lat = 2; e.nwe = 1; r = int'(w[7:0]); end
      4'h2: begin e.lat = 3; e.nwe = 1; r = a; end
      4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
        e.lat = 4; e.nwe = 1; e.c = 1'b0;
        case (op)
          4'h3: begin r = b + a; e.c = (r > 255); end
          4'h4: begin r = b - a; e.c = (a > b); end
          4'h5: r = b & a;
          4'h6: r = b | a;
          default: r = b ^ a;
        endcase
        r = r & 255;
        e.z = (r == 0);
      end
      4'h8: begin e.lat = 3 + stall; e.nout = stall + 1; e.odata = mregs[rd]; end
      4'hF: begin e.lat = 1; e.halt = 1; end
      default: begin
        e.lat = 1; e.ill = 1;
`ifdef SEQ_ILLEGAL_HALT_EN
        e.halt = 1;
`endif
      end
    endcase
    e.wdata = r[7:0];
    if (e.nwe != 0) mregs[rd] = e.wdata;
    mz = e.z; mc = e.c;
  endtask

  // Issues one instruction and records what the DUT does until it is ready again (or halts).
  task automatic exec_instr(input logic [15:0] w, input int stall, output obs_t o);
    int k = 0;
    int guard = 0;
    o = '{default: 0};
    while (!instr_ready && guard < 40) begin @(negedge clk); guard++; end
    instr = w; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0; instr = '0;
    o.lat = 1; o.addr1 = reg_addr; o.ill = illegal ? 1 : 0;
    while (!instr_ready && !halted && o.lat < 40) begin
      if (reg_we) begin o.nwe++; o.waddr = reg_addr; o.wdata = reg_wdata; end
      else if (reg_wdata !== 8'h00) o.leak = 1;
      if (out_valid) begin
        if (o.nout == 0) o.odata = out_data;
        else if (out_data !== o.odata) o.unstable = 1;
        o.nout++;
        out_ready = (k >= stall);
        k++;
      end else if (out_data !== 8'h00) o.leak = 1;
      @(negedge clk);
      out_ready = 1'b0;
      o.lat++;
      if (illegal) o.ill++;
    end
    o.halt = halted;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mz = 1'b0; mc = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b0; instr = '0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin rf[i] = 8'h00; mregs[i] = 8'h00; end
    repeat (2) @(negedge clk);
    checks++; if (instr_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 0", instr_ready); end
    checks++; if (reg_we !== 1'b0 || reg_addr !== 3'd0) begin failures++; $display("[TB] FAIL reset_we: got we=%b addr=%0d expected 0/0", reg_we, reg_addr); end
    checks++; if ({flag_z, flag_c, illegal, halted, out_valid} !== 5'b0) begin failures++; $display("[TB] FAIL reset_outs: got z c ill halt ov=%b expected 00000", {flag_z, flag_c, illegal, halted, out_valid}); end
    rst = 1'b0;
    #1;
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_release_ready: got %b expected 1", instr_ready); end
    @(negedge clk);
  endtask

  task automatic test_ldi();
    obs_t o; exp_t e;
    model_step(enc(4'h1, 3'd3, 8'h5A), 0, e);
    exec_instr(enc(4'h1, 3'd3, 8'h5A), 0, o);
    checks++; if (o.lat !== 2) begin failures++; $display("[TB] FAIL ldi_latency: got %0d expected 2", o.lat); end
    checks++; if (o.nwe !== 1 || o.addr1 !== 3'd3) begin failures++; $display("[TB] FAIL ldi_we: got nwe=%0d addr=%0d expected 1/3", o.nwe, o.addr1); end
    checks++; if (o.wdata !== 8'h5A) begin failures++; $display("[TB] FAIL ldi_wdata: got %h expected 5a", o.wdata); end
  endtask

  task automatic test_alu_flags();
    obs_t o; exp_t e;
    model_step(enc(4'h1, 3'd1, 8'hF0), 0, e); exec_instr(enc(4'h1, 3'd1, 8'hF0), 0, o);
    model_step(enc(4'h1, 3'd2, 8'h20), 0, e); exec_instr(enc(4'h1, 3'd2, 8'h20), 0, o);
    model_step(enc(4'h3, 3'd1, 8'h02), 0, e); exec_instr(enc(4'h3, 3'd1, 8'h02), 0, o);
    checks++; if (o.lat !== 4 || o.waddr !== 3'd1 || o.wdata !== 8'h10) begin failures++; $display("[TB] FAIL add_wb: got lat=%0d addr=%0d data=%h expected 4/1/10", o.lat, o.waddr, o.wdata); end
    checks++; if (flag_c !== 1'b1 || flag_z !== 1'b0) begin failures++; $display("[TB] FAIL add_flags: got c=%b z=%b expected c=1 z=0", flag_c, flag_z); end
    model_step(enc(4'h4, 3'd2, 8'h02), 0, e); exec_instr(enc(4'h4, 3'd2, 8'h02), 0, o);
    checks++; if (o.waddr !== 3'd2 || o.wdata !== 8'h00) begin failures++; $display("[TB] FAIL sub_wb: got addr=%0d data=%h expected 2/00", o.waddr, o.wdata); end
    checks++; if (flag_z !== 1'b1 || flag_c !== 1'b0) begin failures++; $display("[TB] FAIL sub_flags: got z=%b c=%b expected z=1 c=0", flag_z, flag_c); end
  endtask

  task automatic test_mov();
    obs_t o; exp_t e;
    model_step(enc(4'h2, 3'd4, 8'h01), 0, e);
    exec_instr(enc(4'h2, 3'd4, 8'h01), 0, o);
    checks++; if (o.addr1 !== 3'd1 || o.lat !== 3) begin failures++; $display("[TB] FAIL mov_read: got addr=%0d lat=%0d expected 1/3", o.addr1, o.lat); end
    checks++; if (o.waddr !== 3'd4 || o.wdata !== 8'h10) begin failures++; $display("[TB] FAIL mov_wb: got addr=%0d data=%h expected 4/10", o.waddr, o.wdata); end
    checks++; if (flag_z !== 1'b1 || flag_c !== 1'b0) begin failures++; $display("[TB] FAIL mov_flags: got z=%b c=%b expected unchanged z=1 c=0", flag_z, flag_c); end
  endtask

  task automatic test_out_stall();
    obs_t o; exp_t e;
    model_step(enc(4'h8, 3'd4, 8'h00), 5, e);
    exec_instr(enc(4'h8, 3'd4, 8'h00), 5, o);
    checks++; if (o.nout !== 6 || o.odata !== 8'h10) begin failures++; $display("[TB] FAIL out_data: got cycles=%0d data=%h expected 6/10", o.nout, o.odata); end
    checks++; if (o.unstable !== 1'b0 || o.leak !== 1'b0) begin failures++; $display("[TB] FAIL out_stable: got unstable=%b leak=%b expected 0/0", o.unstable, o.leak); end
    checks++; if (o.lat !== 8 || o.nwe !== 0) begin failures++; $display("[TB] FAIL out_latency: got lat=%0d nwe=%0d expected 8/0", o.lat, o.nwe); end
  endtask

  task automatic test_illegal();
    obs_t o; exp_t e;
    model_step(enc(4'hA, 3'd0, 8'h00), 0, e);
    exec_instr(enc(4'hA, 3'd0, 8'h00), 0, o);
    checks++; if (o.ill !== 1 || o.nwe !== 0) begin failures++; $display("[TB] FAIL illegal_pulse: got ill=%0d nwe=%0d expected 1/0", o.ill, o.nwe); end
`ifdef SEQ_ILLEGAL_HALT_EN
    checks++; if (halted !== 1'b1 || instr_ready !== 1'b0) begin failures++; $display("[TB] FAIL illegal_halt: got halted=%b ready=%b expected 1/0", halted, instr_ready); end
    @(negedge clk);
    checks++; if (illegal !== 1'b0 || halted !== 1'b1) begin failures++; $display("[TB] FAIL illegal_after: got ill=%b halted=%b expected 0/1", illegal, halted); end
    apply_reset();
`else
    checks++; if (o.lat !== 1 || instr_ready !== 1'b1) begin failures++; $display("[TB] FAIL illegal_skip: got lat=%0d ready=%b expected 1/1", o.lat, instr_ready); end
    model_step(enc(4'h1, 3'd5, 8'h33), 0, e);
    exec_instr(enc(4'h1, 3'd5, 8'h33), 0, o);
    checks++; if (o.ill !== 0 || o.lat !== 2 || o.wdata !== 8'h33) begin failures++; $display("[TB] FAIL illegal_next: got ill=%0d lat=%0d data=%h expected 0/2/33", o.ill, o.lat, o.wdata); end
`endif
  endtask

  task automatic test_random();
    obs_t o; exp_t e;
    logic [3:0] op;
    logic [15:0] w;
    int sel, stall;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 9) begin
`ifdef SEQ_ILLEGAL_HALT_EN
        op = 4'h0;
`else
        op = 4'(9 + $urandom_range(0, 5));
`endif
      end else op = 4'(sel);
      w = enc(op, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      stall = $urandom_range(0, 3);
      model_step(w, stall, e);
      exec_instr(w, stall, o);
      checks++; if (o.lat !== e.lat) begin failures++; $display("[TB] FAIL rand_latency #%0d instr=%h: got %0d expected %0d", i, w, o.lat, e.lat); end
      checks++; if (o.nwe !== e.nwe || (e.nwe != 0 && (o.waddr !== e.waddr || o.wdata !== e.wdata))) begin
        failures++; $display("[TB] FAIL rand_write #%0d instr=%h: got n=%0d a=%0d d=%h expected n=%0d a=%0d d=%h", i, w, o.nwe, o.waddr, o.wdata, e.nwe, e.waddr, e.wdata);
      end
      checks++; if (o.nout !== e.nout || (e.nout != 0 && o.odata !== e.odata) || o.unstable || o.leak) begin
        failures++; $display("[TB] FAIL rand_out #%0d instr=%h: got n=%0d d=%h unst=%b leak=%b expected n=%0d d=%h", i, w, o.nout, o.odata, o.unstable, o.leak, e.nout, e.odata);
      end
      checks++; if (flag_z !== e.z || flag_c !== e.c || o.ill !== e.ill) begin
        failures++; $display("[TB] FAIL rand_flags #%0d instr=%h: got z=%b c=%b ill=%0d expected z=%b c=%b ill=%0d", i, w, flag_z, flag_c, o.ill, e.z, e.c, e.ill);
      end
    end
    @(negedge clk);
    for (int r = 0; r < 8; r++) begin
      checks++; if (rf[r] !== mregs[r]) begin failures++; $display("[TB] FAIL rand_regfile r%0d: got %h expected %h", r, rf[r], mregs[r]); end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o; exp_t e;
    model_step(enc(4'h1, 3'd1, 8'hFF), 0, e); exec_instr(enc(4'h1, 3'd1, 8'hFF), 0, o);
    model_step(enc(4'h1, 3'd2, 8'h01), 0, e); exec_instr(enc(4'h1, 3'd2, 8'h01), 0, o);
    model_step(enc(4'h3, 3'd1, 8'h02), 0, e); exec_instr(enc(4'h3, 3'd1, 8'h02), 0, o);
    checks++; if (flag_z !== 1'b1 || flag_c !== 1'b1) begin failures++; $display("[TB] FAIL mid_pre_flags: got z=%b c=%b expected 1/1", flag_z, flag_c); end
    instr = enc(4'h3, 3'd1, 8'h02); instr_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (reg_addr !== 3'd1 || reg_we !== 1'b0) begin failures++; $display("[TB] FAIL mid_rd_d: got addr=%0d we=%b expected 1/0", reg_addr, reg_we); end
    rst = 1'b1;
    #1;
    checks++; if ({reg_we, instr_ready, out_valid, halted, illegal, flag_z, flag_c} !== 7'b0 || reg_addr !== 3'd0 || reg_wdata !== 8'h00) begin
      failures++; $display("[TB] FAIL mid_reset_outs: got we rdy ov halt ill z c=%b addr=%0d wdata=%h expected all 0", {reg_we, instr_ready, out_valid, halted, illegal, flag_z, flag_c}, reg_addr, reg_wdata);
    end
    @(negedge clk);
    rst = 1'b0; mz = 1'b0; mc = 1'b0;
    #1;
    checks++; if (instr_ready !== 1'b1 || flag_z !== 1'b0 || flag_c !== 1'b0) begin failures++; $display("[TB] FAIL mid_release: got ready=%b z=%b c=%b expected 1/0/0", instr_ready, flag_z, flag_c); end
    @(negedge clk); @(negedge clk);
    checks++; if (rf[1] !== mregs[1]) begin failures++; $display("[TB] FAIL mid_no_write: got r1=%h expected %h", rf[1], mregs[1]); end
  endtask

  task automatic test_halt();
    obs_t o; exp_t e;
    model_step(enc(4'hF, 3'd0, 8'h00), 0, e);
    exec_instr(enc(4'hF, 3'd0, 8'h00), 0, o);
    checks++; if (o.halt !== 1'b1 || o.lat !== 1) begin failures++; $display("[TB] FAIL halt_enter: got halted=%b lat=%0d expected 1/1", o.halt, o.lat); end
    instr = enc(4'h1, 3'd6, 8'h77); instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (halted !== 1'b1 || instr_ready !== 1'b0 || reg_we !== 1'b0) begin failures++; $display("[TB] FAIL halt_hold cycle %0d: got halted=%b ready=%b we=%b expected 1/0/0", i, halted, instr_ready, reg_we); end
    end
    instr_valid = 1'b0;
    apply_reset();
    #1;
    checks++; if (halted !== 1'b0 || instr_ready !== 1'b1 || rf[6] !== mregs[6]) begin failures++; $display("[TB] FAIL halt_exit: got halted=%b ready=%b r6=%h expected 0/1/%h", halted, instr_ready, rf[6], mregs[6]); end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_ldi();
    test_alu_flags();
    test_mov();
    test_out_stall();
    test_illegal();
    test_random();
    test_reset_mid();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
